// File: rtl/prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Holds the fetch FSM state encoding and the segment:offset address formation.
package prefetch_queue_pkg;

  localparam int PREFETCH_DEPTH = 8;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_FETCH   = 2'd1,
    PF_DISCARD = 2'd2
  } prefetch_state_e;

  // Word-aligned physical address; the offset wraps inside the segment, the sum wraps at 1 MiB.
  function automatic logic [19:0] seg_addr(input logic [15:0] ps, input logic [15:0] pc);
    logic [19:0] sum;
    sum = {ps, 4'h0} + {4'h0, pc};
    return {sum[19:1], 1'b0};
  endfunction

endpackage

// File: rtl/prefetch_queue_byte_shift_queue.sv
// Byte FIFO with a left-aligned window: pops N bytes from the head and appends
// 0..2 bytes at the post-pop tail in the same cycle.
module byte_shift_queue #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [1:0]         push_count,
  input  logic [15:0]        push_data,
  input  logic [3:0]         pop_count,
  output logic [8*DEPTH-1:0] q_bytes,
  output logic [3:0]         q_count
);

  logic [8*DEPTH-1:0] data_r;
  logic [8*DEPTH-1:0] shifted_s;
  logic [8*DEPTH-1:0] data_nxt_s;
  logic [3:0]         count_r;
  logic [3:0]         count_nxt_s;
  logic [4:0]         tail_s;

  // Shift out consumed bytes, then drop pushed bytes in at the new tail.
  always_comb begin
    shifted_s   = data_r >> {pop_count, 3'b000};
    tail_s      = {1'b0, count_r} - {1'b0, pop_count};
    data_nxt_s  = shifted_s;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_count != 2'd0 && tail_s == 5'(i)) begin
        data_nxt_s[8*i +: 8] = push_data[7:0];
      end else if (push_count == 2'd2 && (tail_s + 5'd1) == 5'(i)) begin
        data_nxt_s[8*i +: 8] = push_data[15:8];
      end else begin
        data_nxt_s[8*i +: 8] = shifted_s[8*i +: 8];
      end
    end
    count_nxt_s = 4'(tail_s + {3'b000, push_count});
  end

  // Storage and occupancy; clear only empties the window, stale bytes are don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else begin
      data_r  <= data_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign q_bytes = data_r;
  assign q_count = count_r;

endmodule

// File: rtl/prefetch_queue_checker.sv
// Simulation-only protocol checks on the decoder side of the prefetch queue.
// Flags consumes of zero bytes or of more bytes than the window holds.
module prefetch_queue_checker #(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       reset,
  input logic       consume,
  input logic [3:0] consume_size,
  input logic [3:0] q_count
);

  consume_legal_a: assert property (@(posedge clk) disable iff (reset)
    consume |-> (consume_size != 4'd0 && consume_size <= q_count));

  count_bound_a: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, q_count} <= 5'(DEPTH)));

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words at PS:PC and presents a
// left-aligned byte window to the pre-decoder, restarting on every flush.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = PREFETCH_DEPTH,
  parameter logic [15:0] RESET_PS = 16'hFFFF,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               bus_req,
  output logic [19:0]        bus_addr,
  input  logic               bus_ack,
  input  logic [15:0]        bus_data,
  input  logic               flush,
  input  logic [15:0]        flush_ps,
  input  logic [15:0]        flush_pc,
  input  logic               consume,
  input  logic [3:0]         consume_size,
  output logic [8*DEPTH-1:0] q_bytes,
  output logic [3:0]         q_count,
  output logic [15:0]        q_pc,
  output logic [15:0]        q_ps
);

  prefetch_state_e state_r;
  prefetch_state_e state_nxt_s;
  logic [15:0]     fetch_pc_r;
  logic [15:0]     q_ps_r;
  logic [15:0]     q_pc_r;
  logic [19:0]     req_addr_r;
  logic [4:0]      space_s;
  logic            start_s;
  logic            ack_take_s;
  logic [1:0]      push_count_s;
  logic [15:0]     push_data_s;
  logic [3:0]      pop_count_s;

  // An odd fetch_pc only needs one free byte since the low byte is dropped.
  always_comb begin
    space_s = 5'(DEPTH) - {1'b0, q_count};
    start_s = !reset && !flush &&
              ((space_s >= 5'd2) || (space_s >= 5'd1 && fetch_pc_r[0]));
  end

  // Next-state and bus request; the request is raised in the same cycle IDLE decides to fetch.
  always_comb begin
    state_nxt_s = state_r;
    bus_req     = 1'b0;
    ack_take_s  = 1'b0;
    case (state_r)
      PF_IDLE: begin
        if (start_s) begin
          state_nxt_s = PF_FETCH;
          bus_req     = 1'b1;
        end else begin
          state_nxt_s = PF_IDLE;
        end
      end
      PF_FETCH: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_nxt_s = PF_IDLE;
          ack_take_s  = !flush;
        end else if (flush) begin
          state_nxt_s = PF_DISCARD;
        end else begin
          state_nxt_s = PF_FETCH;
        end
      end
      PF_DISCARD: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_nxt_s = PF_IDLE;
        end else begin
          state_nxt_s = PF_DISCARD;
        end
      end
      default: begin
        state_nxt_s = PF_IDLE;
      end
    endcase
  end

  // In IDLE the address is formed live; once issued it is held until the ack.
  always_comb begin
    if (state_r == PF_IDLE) begin
      bus_addr = seg_addr(q_ps_r, fetch_pc_r);
    end else begin
      bus_addr = req_addr_r;
    end
  end

  // Queue controls: flush overrides both pop and push, odd fetch keeps only the high byte.
  always_comb begin
    push_count_s = 2'd0;
    push_data_s  = bus_data;
    pop_count_s  = 4'd0;
    if (ack_take_s) begin
      if (fetch_pc_r[0]) begin
        push_count_s = 2'd1;
        push_data_s  = {8'h00, bus_data[15:8]};
      end else begin
        push_count_s = 2'd2;
        push_data_s  = bus_data;
      end
    end else begin
      push_count_s = 2'd0;
      push_data_s  = bus_data;
    end
    if (consume && !flush) begin
      pop_count_s = consume_size;
    end else begin
      pop_count_s = 4'd0;
    end
  end

  // FSM, fetch pointer, decode PC/PS and the latched request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= PF_IDLE;
      fetch_pc_r <= RESET_PC;
      q_ps_r     <= RESET_PS;
      q_pc_r     <= RESET_PC;
      req_addr_r <= 20'h00000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == PF_IDLE && start_s) begin
        req_addr_r <= seg_addr(q_ps_r, fetch_pc_r);
      end
      if (flush) begin
        q_ps_r     <= flush_ps;
        q_pc_r     <= flush_pc;
        fetch_pc_r <= flush_pc;
      end else begin
        if (consume) begin
          q_pc_r <= q_pc_r + {12'h000, consume_size};
        end
        if (ack_take_s) begin
          fetch_pc_r <= fetch_pc_r + (fetch_pc_r[0] ? 16'd1 : 16'd2);
        end
      end
    end
  end

  byte_shift_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push_count(push_count_s),
    .push_data (push_data_s),
    .pop_count (pop_count_s),
    .q_bytes   (q_bytes),
    .q_count   (q_count)
  );

  prefetch_queue_checker #(
    .DEPTH(DEPTH)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .consume     (consume),
    .consume_size(consume_size),
    .q_count     (q_count)
  );

  assign q_pc = q_pc_r;
  assign q_ps = q_ps_r;

endmodule
